// File: rtl/vga_capture_apb.sv
// vga_capture_apb
// Frame grabber. It samples a 24-bit VGA pixel stream, tracks the pixel
// coordinates and queues each pixel in a small FIFO. An APB3 initiator then
// writes every queued pixel into a frame buffer at BASE_ADDR + {y,x,2'b00}.
//
// Ports
//   clock, reset            system clock; asynchronous active-low reset
//   capture_start           1-cycle pulse that arms capture of the next frame
//   vga_r/g/b, vga_hsync,   pixel stream (hsync is accepted but not needed,
//   vga_vsync, vga_valid    because lines are delimited by vga_valid)
//   out_p*                  APB3 initiator port (out_prdata is ignored)
//   busy                    capture FSM is not idle
//   frame_done              1-cycle pulse once the frame is fully written
//   overflow                sticky: a pixel was dropped on a full FIFO
//   slverr                  sticky: a write completed with pslverr=1
module vga_capture_apb #(
  parameter logic [31:0] BASE_ADDR  = 32'h2100_0000,
  parameter int          FIFO_DEPTH = 8,
  parameter int          H_MAX      = 640,
  parameter int          V_MAX      = 480
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        capture_start,
  input  logic [7:0]  vga_r,
  input  logic [7:0]  vga_g,
  input  logic [7:0]  vga_b,
  input  logic        vga_hsync,
  input  logic        vga_vsync,
  input  logic        vga_valid,
  output logic [31:0] out_paddr,
  output logic        out_psel,
  output logic        out_penable,
  output logic        out_pwrite,
  output logic [31:0] out_pwdata,
  output logic [3:0]  out_pstrb,
  output logic [2:0]  out_pprot,
  input  logic        out_pready,
  input  logic [31:0] out_prdata,
  input  logic        out_pslverr,
  output logic        busy,
  output logic        frame_done,
  output logic        overflow,
  output logic        slverr
);

  localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CNT_W = $clog2(FIFO_DEPTH + 1);
  localparam logic [CNT_W-1:0] FULL_COUNT = CNT_W'(FIFO_DEPTH);
  localparam logic [10:0] H_LIM = 11'(H_MAX);
  localparam logic [10:0] V_LIM = 11'(V_MAX);

  typedef enum logic [1:0] {C_IDLE, C_WAIT, C_RUN, C_DRAIN} cap_state_t;
  typedef enum logic [1:0] {A_IDLE, A_SETUP, A_ACCESS} apb_state_t;

  cap_state_t cap_state_q, cap_state_d;
  apb_state_t apb_state_q, apb_state_d;

  logic             vsync_q, vsync_d;
  logic             valid_q, valid_d;
  logic [9:0]       x_q, x_d;
  logic [9:0]       y_q, y_d;
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             overflow_q, overflow_d;
  logic             slverr_q, slverr_d;

  logic [43:0] fifo_mem_q [FIFO_DEPTH];
  logic [43:0] head;

  logic vsync_rise, vsync_fall, valid_fall;
  logic fifo_full, fifo_empty, in_range, pixel_req, push, pop, drop;

  logic unused_inputs;
  assign unused_inputs = ^{vga_hsync, out_prdata};

  // Edges are found against a single registered copy of each input.
  assign vsync_rise = vga_vsync & ~vsync_q;
  assign vsync_fall = ~vga_vsync & vsync_q;
  assign valid_fall = valid_q & ~vga_valid;
  assign vsync_d    = vga_vsync;
  assign valid_d    = vga_valid;

  assign fifo_full  = (count_q == FULL_COUNT);
  assign fifo_empty = (count_q == '0);
  assign in_range   = ({1'b0, x_q} < H_LIM) && ({1'b0, y_q} < V_LIM);
  assign pixel_req  = (cap_state_q == C_RUN) && vga_valid;

  // A pop in the same cycle frees the slot, so a full FIFO still accepts.
  assign pop  = (apb_state_q == A_ACCESS) && out_pready;
  assign push = pixel_req && in_range && (!fifo_full || pop);
  assign drop = pixel_req && in_range && fifo_full && !pop;

  // FIFO bookkeeping; occupancy comes from the count, not pointer equality.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
    if (pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
    case ({push, pop})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
  end

  // Capture FSM, coordinate counters and sticky status flags.
  always_comb begin
    cap_state_d = cap_state_q;
    x_d         = x_q;
    y_d         = y_q;
    overflow_d  = overflow_q;
    slverr_d    = slverr_q;
    frame_done  = 1'b0;
    case (cap_state_q)
      C_IDLE: begin
        if (capture_start) begin
          cap_state_d = C_WAIT;
          overflow_d  = 1'b0;
          slverr_d    = 1'b0;
        end
      end
      C_WAIT: begin
        if (vsync_rise) begin
          cap_state_d = C_RUN;
          x_d         = '0;
          y_d         = '0;
        end
      end
      C_RUN: begin
        if (vga_valid) begin
          x_d = (x_q == 10'h3FF) ? x_q : x_q + 10'd1;
        end else if (valid_fall) begin
          x_d = '0;
          y_d = (y_q == 10'h3FF) ? y_q : y_q + 10'd1;
        end
        if (vsync_fall) cap_state_d = C_DRAIN;
      end
      C_DRAIN: begin
        if (fifo_empty && (apb_state_q == A_IDLE)) begin
          cap_state_d = C_IDLE;
          frame_done  = 1'b1;
        end
      end
      default: cap_state_d = C_IDLE;
    endcase
    if (drop) overflow_d = 1'b1;
    if (pop && out_pslverr) slverr_d = 1'b1;
  end

  // APB3 initiator; ACCESS chains straight into SETUP while data remains.
  always_comb begin
    apb_state_d = apb_state_q;
    case (apb_state_q)
      A_IDLE:   if (!fifo_empty) apb_state_d = A_SETUP;
      A_SETUP:  apb_state_d = A_ACCESS;
      A_ACCESS: begin
        if (out_pready) apb_state_d = (count_d != '0) ? A_SETUP : A_IDLE;
      end
      default:  apb_state_d = A_IDLE;
    endcase
  end

  // The head entry only moves on a pop, so address/data hold through waits.
  assign head        = fifo_mem_q[rd_ptr_q];
  assign out_psel    = (apb_state_q != A_IDLE);
  assign out_penable = (apb_state_q == A_ACCESS);
  assign out_pwrite  = out_psel;
  assign out_pstrb   = out_psel ? 4'b0111 : 4'b0000;
  assign out_pprot   = 3'b000;
  assign out_paddr   = out_psel ? (BASE_ADDR + {10'd0, head[43:34], head[33:24], 2'b00}) : 32'd0;
  assign out_pwdata  = out_psel ? {8'h00, head[23:0]} : 32'd0;
  assign busy        = (cap_state_q != C_IDLE);
  assign overflow    = overflow_q;
  assign slverr      = slverr_q;

  // Pixel storage carries no reset; the count alone says what is valid.
  always_ff @(posedge clock) begin
    if (push) fifo_mem_q[wr_ptr_q] <= {y_q, x_q, vga_r, vga_g, vga_b};
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      cap_state_q <= C_IDLE;
      apb_state_q <= A_IDLE;
      vsync_q     <= 1'b0;
      valid_q     <= 1'b0;
      x_q         <= '0;
      y_q         <= '0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      overflow_q  <= 1'b0;
      slverr_q    <= 1'b0;
    end else begin
      cap_state_q <= cap_state_d;
      apb_state_q <= apb_state_d;
      vsync_q     <= vsync_d;
      valid_q     <= valid_d;
      x_q         <= x_d;
      y_q         <= y_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      overflow_q  <= overflow_d;
      slverr_q    <= slverr_d;
    end
  end

endmodule

// File: tb/tb_vga_capture_apb.sv
// Testbench for vga_capture_apb: drives VGA frames, plays an APB target with
// configurable wait states and error injection, and compares every completed
// write against a queue of expected {address, data} pairs built from pixel
// coordinates.
module tb_vga_capture_apb;

  localparam logic [31:0] BASE = 32'h2100_0000;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        captureStart = 1'b0;
  logic [7:0]  vgaR = '0, vgaG = '0, vgaB = '0;
  logic        vgaHsync = 1'b1, vgaVsync = 1'b1, vgaValid = 1'b0;
  logic        pready = 1'b0, pslverr = 1'b0;
  logic [31:0] prdata = '0;
  logic [31:0] paddr, pwdata;
  logic        psel, penable, pwrite;
  logic [3:0]  pstrb;
  logic [2:0]  pprot;
  logic        busy, frameDone, overflow, slverr;

  vga_capture_apb dut (
    .clock(clock), .reset(reset), .capture_start(captureStart),
    .vga_r(vgaR), .vga_g(vgaG), .vga_b(vgaB),
    .vga_hsync(vgaHsync), .vga_vsync(vgaVsync), .vga_valid(vgaValid),
    .out_paddr(paddr), .out_psel(psel), .out_penable(penable), .out_pwrite(pwrite),
    .out_pwdata(pwdata), .out_pstrb(pstrb), .out_pprot(pprot),
    .out_pready(pready), .out_prdata(prdata), .out_pslverr(pslverr),
    .busy(busy), .frame_done(frameDone), .overflow(overflow), .slverr(slverr)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic [31:0] addr;
    logic [31:0] data;
  } write_t;

  typedef struct {
    int       nLines;
    int       nPix;
    int       waits;
    int       errIdx;
    int       expWrites;
    bit       expOverflow;
    bit       expSlverr;
  } vec_t;

  write_t      expQ[$];
  int          checks = 0;
  int          failures = 0;
  bit          scoreOn = 1'b1;
  bit          randomWaits = 1'b0;
  bit          holdReady = 1'b0;
  int          waitTarget = 0;
  int          errAt = -1;
  int          accCycles = 0;
  int          writesInFrame = 0;
  int          frameDoneCount = 0;
  int          pselSeen = 0;
  int          maxX = 0;
  logic [31:0] setupAddr = '0, setupData = '0;

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s: actual=%0h required=%0h", name, actual, expected);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clock);
  endtask

  // APB target model plus write monitor, evaluated away from the rising edge.
  always @(negedge clock) begin
    logic [31:0] off;
    write_t e;
    if (frameDone) frameDoneCount++;
    if (psel) pselSeen++;
    if (psel && !penable) begin
      setupAddr = paddr;
      setupData = pwdata;
      accCycles = 0;
      if (randomWaits) waitTarget = $urandom_range(0, 3);
    end
    if (holdReady) begin
      pready  = 1'b0;
      pslverr = 1'b0;
    end else if (psel && penable) begin
      pready  = (accCycles >= waitTarget);
      pslverr = pready && (writesInFrame == errAt);
      accCycles++;
    end else begin
      pready  = 1'b0;
      pslverr = 1'b0;
    end
    if (psel && penable) begin
      checkOutput("accessStable.paddr", paddr, setupAddr);
      checkOutput("accessStable.pwdata", pwdata, setupData);
      checkOutput("access.pstrb", {28'd0, pstrb}, 32'h7);
      checkOutput("access.pwrite", {31'd0, pwrite}, 32'h1);
    end
    if (psel && penable && pready) begin
      writesInFrame++;
      off = paddr - BASE;
      if (int'(off[11:2]) > maxX) maxX = int'(off[11:2]);
      if (scoreOn) begin
        if (expQ.size() == 0) begin
          checks++;
          failures++;
          $display("[TB] FAIL unexpectedWrite: actual addr=%0h data=%0h required=none", paddr, pwdata);
        end else begin
          e = expQ.pop_front();
          checkOutput("write.addr", paddr, e.addr);
          checkOutput("write.data", pwdata, e.data);
        end
      end
    end
  end

  task automatic waitQuiet();
    int quiet = 0;
    int budget = 0;
    while (quiet < 2 && budget < 500) begin
      tick(1);
      quiet = psel ? 0 : quiet + 1;
      budget++;
    end
    checkOutput("drainWithinBudget", {31'd0, quiet >= 2}, 32'h1);
  endtask

  task automatic waitFrameDone();
    int budget = 0;
    while (frameDoneCount == 0 && budget < 3000) begin
      tick(1);
      budget++;
    end
    checkOutput("frameDoneWithinBudget", {31'd0, frameDoneCount != 0}, 32'h1);
    tick(3);
  endtask

  // Arms a capture and plays one frame; the expected-write queue is filled
  // from the pixel coordinates as each in-range pixel is driven.
  task automatic applyStimulus(input int nLines, input int nPix, input logic [23:0] rgbBase,
                               input bit drain, input bit midStart);
    int n = 0;
    logic [23:0] rgb;
    write_t w;
    writesInFrame  = 0;
    frameDoneCount = 0;
    maxX           = 0;
    @(negedge clock) captureStart = 1'b1;
    @(negedge clock) captureStart = 1'b0;
    vgaVsync = 1'b0;
    tick(3);
    vgaVsync = 1'b1;
    tick(3);
    for (int y = 0; y < nLines; y++) begin
      vgaHsync = 1'b0;
      tick(2);
      vgaHsync = 1'b1;
      tick(2);
      for (int x = 0; x < nPix; x++) begin
        rgb = rgbBase + 24'(n);
        {vgaR, vgaG, vgaB} = rgb;
        vgaValid = 1'b1;
        if (scoreOn && x < 640 && y < 480) begin
          w.addr = BASE + 32'(y * 4096 + x * 4);
          w.data = {8'h00, rgb};
          expQ.push_back(w);
        end
        n++;
        tick(1);
      end
      vgaValid = 1'b0;
      {vgaR, vgaG, vgaB} = 24'd0;
      if (midStart) begin
        captureStart = 1'b1;
        tick(1);
        captureStart = 1'b0;
        tick(1);
        checkOutput("midStart.overflowKept", {31'd0, overflow}, 32'h1);
        checkOutput("midStart.busy", {31'd0, busy}, 32'h1);
      end
      if (drain) waitQuiet();
      else tick(4);
    end
    vgaVsync = 1'b0;
    tick(2);
  endtask

  vec_t vecs[5];

  initial begin
    #500_000;
    $display("[TB] FAIL watchdog: simulation did not complete, failures so far=%0d", failures);
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int total;
    bit expErr;

    vecs[0] = '{2, 4, 0, -1, 8, 1'b0, 1'b0};
    vecs[1] = '{2, 4, 3, -1, 8, 1'b0, 1'b0};
    vecs[2] = '{3, 5, 1, 2, 15, 1'b0, 1'b1};
    vecs[3] = '{1, 8, 0, -1, 8, 1'b0, 1'b0};
    vecs[4] = '{4, 1, 2, -1, 4, 1'b0, 1'b0};

    // Reset state.
    #2 reset = 1'b0;
    tick(3);
    checkOutput("reset.psel", {31'd0, psel}, 32'h0);
    checkOutput("reset.penable", {31'd0, penable}, 32'h0);
    checkOutput("reset.paddr", paddr, 32'h0);
    checkOutput("reset.pwdata", pwdata, 32'h0);
    checkOutput("reset.pstrb", {28'd0, pstrb}, 32'h0);
    checkOutput("reset.pprot", {29'd0, pprot}, 32'h0);
    checkOutput("reset.status", {28'd0, busy, frameDone, overflow, slverr}, 32'h0);
    reset = 1'b1;
    tick(3);

    // Table-driven frames with fixed wait states and error injection.
    for (int i = 0; i < 5; i++) begin
      scoreOn     = 1'b1;
      randomWaits = 1'b0;
      waitTarget  = vecs[i].waits;
      errAt       = vecs[i].errIdx;
      applyStimulus(vecs[i].nLines, vecs[i].nPix, (i == 0) ? 24'h010203 : 24'(i * 24'h111100), 1'b1, 1'b0);
      waitFrameDone();
      checkOutput($sformatf("vec%0d.writes", i), writesInFrame, vecs[i].expWrites);
      checkOutput($sformatf("vec%0d.overflow", i), {31'd0, overflow}, {31'd0, vecs[i].expOverflow});
      checkOutput($sformatf("vec%0d.slverr", i), {31'd0, slverr}, {31'd0, vecs[i].expSlverr});
      checkOutput($sformatf("vec%0d.frameDonePulses", i), frameDoneCount, 1);
      checkOutput($sformatf("vec%0d.busyAfter", i), {31'd0, busy}, 32'h0);
      checkOutput($sformatf("vec%0d.pendingExpected", i), expQ.size(), 0);
      vgaVsync = 1'b1;
      tick(2);
    end

    // pready held low across a 16-pixel line: FIFO fills, the rest drop.
    scoreOn   = 1'b0;
    errAt     = -1;
    waitTarget = 0;
    holdReady = 1'b1;
    applyStimulus(1, 16, 24'h00aa00, 1'b0, 1'b0);
    checkOutput("hold.overflowSet", {31'd0, overflow}, 32'h1);
    holdReady = 1'b0;
    waitFrameDone();
    checkOutput("hold.writes8or9", {31'd0, (writesInFrame == 8) || (writesInFrame == 9)}, 32'h1);
    vgaVsync = 1'b1;
    tick(2);
    @(negedge clock) captureStart = 1'b1;
    @(negedge clock) captureStart = 1'b0;
    checkOutput("hold.overflowCleared", {31'd0, overflow}, 32'h0);
    checkOutput("hold.armedBusy", {31'd0, busy}, 32'h1);

    // Random frames with random wait states against the expected-write queue.
    scoreOn     = 1'b1;
    randomWaits = 1'b1;
    for (int r = 0; r < 6; r++) begin
      int nl = $urandom_range(1, 3);
      int np = $urandom_range(1, 8);
      total  = nl * np;
      errAt  = $urandom_range(0, 2 * total);
      expErr = (errAt < total);
      applyStimulus(nl, np, 24'($urandom), 1'b1, 1'b0);
      waitFrameDone();
      checkOutput($sformatf("rand%0d.writes", r), writesInFrame, total);
      checkOutput($sformatf("rand%0d.overflow", r), {31'd0, overflow}, 32'h0);
      checkOutput($sformatf("rand%0d.slverr", r), {31'd0, slverr}, {31'd0, expErr});
      checkOutput($sformatf("rand%0d.frameDonePulses", r), frameDoneCount, 1);
      checkOutput($sformatf("rand%0d.pendingExpected", r), expQ.size(), 0);
      vgaVsync = 1'b1;
      tick(2);
    end
    randomWaits = 1'b0;

    // 700-pixel line with a capture_start pulse mid-frame.
    scoreOn    = 1'b0;
    errAt      = -1;
    waitTarget = 0;
    applyStimulus(1, 700, 24'h123400, 1'b0, 1'b1);
    waitFrameDone();
    checkOutput("wide.maxXBelow640", {31'd0, maxX < 640}, 32'h1);
    checkOutput("wide.maxXNearEdge", {31'd0, maxX >= 600}, 32'h1);
    checkOutput("wide.writesBounded", {31'd0, (writesInFrame > 8) && (writesInFrame <= 640)}, 32'h1);
    checkOutput("wide.overflow", {31'd0, overflow}, 32'h1);
    checkOutput("wide.frameDonePulses", frameDoneCount, 1);
    vgaVsync = 1'b1;
    tick(2);

    // Reset asserted while a transfer is stalled in ACCESS.
    holdReady = 1'b1;
    applyStimulus(1, 4, 24'h0f0f0f, 1'b0, 1'b0);
    begin
      int budget = 0;
      while (!psel && budget < 50) begin
        tick(1);
        budget++;
      end
    end
    checkOutput("midReset.pselBefore", {31'd0, psel}, 32'h1);
    reset = 1'b0;
    #1;
    checkOutput("midReset.psel", {31'd0, psel}, 32'h0);
    checkOutput("midReset.penable", {31'd0, penable}, 32'h0);
    checkOutput("midReset.paddr", paddr, 32'h0);
    checkOutput("midReset.pwdata", pwdata, 32'h0);
    checkOutput("midReset.pstrbPwrite", {27'd0, pstrb, pwrite}, 32'h0);
    checkOutput("midReset.status", {28'd0, busy, frameDone, overflow, slverr}, 32'h0);
    tick(2);
    vgaVsync  = 1'b1;
    holdReady = 1'b0;
    reset     = 1'b1;
    pselSeen  = 0;
    tick(20);
    checkOutput("afterReset.noApb", pselSeen, 0);
    checkOutput("afterReset.idle", {31'd0, busy}, 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
